// File: rtl/data_sram_pkg.sv
// Shared definitions for the data SRAM responder.
//
// Contents:
//   WORD_W, BYTES : data word width and byte lanes per word
//   PIDX_W        : storage width of the pending-write word index. It holds
//                   the largest index a 32-bit byte address can produce.
//   pend_t        : the one-entry pending-write register
//   in_range()    : checks whether a byte offset falls inside the array
package data_sram_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = 4;
  localparam int PIDX_W = 30;

  typedef struct packed {
    logic              pv;
    logic [PIDX_W-1:0] pidx;
    logic [BYTES-1:0]  pwen;
    logic [WORD_W-1:0] pdata;
  } pend_t;

  // depth is 33 bits wide so that a full 2**30-word array can be described.
  function automatic logic in_range(input logic [31:0] offset,
                                    input logic [32:0] depth);
    return ({3'b000, offset[31:2]} < depth);
  endfunction

endpackage

// File: rtl/data_sram_byte_merge.sv
// Per-lane merge of the pending write over the word read from the array.
//
// Ports:
//   array_word : word currently stored in the array at the read index
//   pend_data  : data held in the pending-write register
//   pend_wen   : byte enables held in the pending-write register
//   hit        : the pending write is valid and targets the read index
//   merged     : array_word with every enabled pending byte replaced
module data_sram_byte_merge
  import data_sram_pkg::*;
(
  input  logic [WORD_W-1:0] array_word,
  input  logic [WORD_W-1:0] pend_data,
  input  logic [BYTES-1:0]  pend_wen,
  input  logic              hit,
  output logic [WORD_W-1:0] merged
);

  always_comb begin
    // NOTE: merged gets a full default before the loop, so no path through
    // this block leaves it unassigned and no latch is inferred.
    merged = array_word;
    for (int i = 0; i < BYTES; i++) begin
      if (hit && pend_wen[i]) begin
        merged[8*i +: 8] = pend_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder side of the data SRAM interface.
//
// It accepts one request per cycle: a byte-masked word write or a word read.
// Read data is registered and returns one cycle after the request. A write
// waits one cycle in a pending-write register before it reaches the array. A
// read of the same word during that cycle sees the new bytes through a bypass.
// The block also flags out-of-range requests.
//
// Optional feature (macro DATA_SRAM_STATS_EN): the block counts in-range reads
// and writes. Without the macro, rd_cnt and wr_cnt are tied to zero and no
// counter flops exist.
//
// Parameters:
//   ADDR_WIDTH : word-index bits; the array holds 2**ADDR_WIDTH 32-bit words
//   BASE_ADDR  : byte address of word 0; must be 4-byte aligned
//
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   data_sram_en    : request valid this cycle
//   data_sram_wen   : byte write enables; nonzero = write, zero = read
//   data_sram_addr  : byte address; bits [1:0] are ignored
//   data_sram_wdata : write data; byte lane i is bits [8i+7:8i]
//   data_sram_rdata : read data, valid the cycle after a read request
//   addr_err        : one-cycle pulse, in step with rdata, for an out-of-range request
//   rd_cnt, wr_cnt  : counts of accepted in-range reads and writes
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_sram_en,
  input  logic [BYTES-1:0]     data_sram_wen,
  input  logic [31:0]          data_sram_addr,
  input  logic [WORD_W-1:0]    data_sram_wdata,
  output logic [WORD_W-1:0]    data_sram_rdata,
  output logic                 addr_err,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [32:0] DEPTH_EXT = 33'd1 << ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  ok_range;
  logic                  rd_req;
  logic                  wr_req;

  // The subtraction wraps modulo 2^32. An address below BASE_ADDR therefore
  // gives a huge offset, and the range check rejects it.
  assign offset   = data_sram_addr - BASE_ADDR;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign ok_range = in_range(offset, DEPTH_EXT);
  assign rd_req   = data_sram_en && (data_sram_wen == '0);
  assign wr_req   = data_sram_en && (data_sram_wen != '0);

  // ---------------------------------------------------------------------------
  // Storage and pending-write register
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  pend_t             pend;

  // The commit is skipped while reset is high. A write still pending when
  // reset arrives is therefore discarded and never reaches the array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch. Clearing every word would prevent
    // RAM inference, and the contents are undefined until written anyway.
    if (!reset && pend.pv) begin
      for (int i = 0; i < BYTES; i++) begin
        if (pend.pwen[i]) begin
          mem[pend.pidx[ADDR_WIDTH-1:0]][8*i +: 8] <= pend.pdata[8*i +: 8];
        end
      end
    end
  end

  // A new write loads pend at the same edge that commits the previous one.
  // Back-to-back writes therefore commit in order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // always_ff block samples the pre-edge values regardless of order.
      pend.pv <= 1'b0;
    end else if (wr_req && ok_range) begin
      pend <= '{pv: 1'b1, pidx: PIDX_W'(idx), pwen: data_sram_wen,
                pdata: data_sram_wdata};
    end else begin
      pend.pv <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path with bypass of the pending write
  // ---------------------------------------------------------------------------
  logic              pend_hit;
  logic [WORD_W-1:0] merged;

  assign pend_hit = pend.pv && (pend.pidx == PIDX_W'(idx));

  data_sram_byte_merge u_merge (
    .array_word (mem[idx]),
    .pend_data  (pend.pdata),
    .pend_wen   (pend.pwen),
    .hit        (pend_hit),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sram_rdata <= '0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= data_sram_en && !ok_range;
      if (rd_req) begin
        data_sram_rdata <= ok_range ? merged : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Access counters
  // ---------------------------------------------------------------------------
`ifdef DATA_SRAM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_req && ok_range) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_req && ok_range) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed testbench for data_sram_responder with default parameters
// (ADDR_WIDTH=16, BASE_ADDR=0). With these defaults, byte address 0x40000 is
// the first out-of-range address.
module tb_data_sram_responder;

  localparam logic [31:0] OOR_ADDR = 32'h0004_0000;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd = 32'd0;
  logic [31:0] exp_wr = 32'd0;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .addr_err        (addr_err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drives one request at the falling edge and returns 1 ns after the rising
  // edge that takes it. The outputs then show the response to this request.
  task automatic issue(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
`ifdef DATA_SRAM_STATS_EN
    if (!reset && en && addr < OOR_ADDR) begin
      if (wen == 4'b0000) exp_rd = exp_rd + 32'd1;
      else                exp_wr = exp_wr + 32'd1;
    end
`endif
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen,
                    input logic [31:0] wdata);
    issue(1'b1, wen, addr, wdata);
  endtask

  task automatic rd(input logic [31:0] addr);
    issue(1'b1, 4'b0000, addr, 32'h0);
  endtask

  task automatic idle();
    issue(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_rd_cnt"}, rd_cnt, exp_rd);
    check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    // Reset state
    idle();
    idle();
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_err", {31'b0, addr_err}, 32'h0);
    check_cnt("rst");
    reset = 1'b0;

    // Full write, one idle cycle, then a read from the array
    wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
    check("wr_holds_rdata", data_sram_rdata, 32'h0);
    check("wr_err", {31'b0, addr_err}, 32'h0);
    idle();
    rd(32'h10);
    check("rd_10", data_sram_rdata, 32'hDEAD_BEEF);
    check("rd_10_err", {31'b0, addr_err}, 32'h0);
    idle();
    check("idle_holds", data_sram_rdata, 32'hDEAD_BEEF);

    // Back-to-back writes to the same word, then reads through bypass and array
    wr(32'h20, 4'b1111, 32'h1122_3344);
    wr(32'h20, 4'b0010, 32'h0000_AA00);
    rd(32'h20);
    check("bypass_20", data_sram_rdata, 32'h1122_AA44);
    idle();
    idle();
    rd(32'h20);
    check("array_20", data_sram_rdata, 32'h1122_AA44);

    // A write followed immediately by a read must beat the stale array value
    wr(32'h30, 4'b1111, 32'h0101_0101);
    idle();
    wr(32'h30, 4'b1111, 32'h5566_7788);
    rd(32'h30);
    check("bypass_30", data_sram_rdata, 32'h5566_7788);

    // Non-contiguous byte lanes over a known word
    wr(32'h50, 4'b1111, 32'hAABB_CCDD);
    idle();
    wr(32'h50, 4'b1001, 32'h1100_0022);
    rd(32'h50);
    check("bypass_lanes", data_sram_rdata, 32'h11BB_CC22);
    rd(32'h54);
    rd(32'h50);
    check("array_lanes", data_sram_rdata, 32'h11BB_CC22);

    // The pending write to 0x60 must not be served to a read of another word
    wr(32'h64, 4'b1111, 32'h0BAD_F00D);
    idle();
    wr(32'h60, 4'b1111, 32'h7777_7777);
    rd(32'h64);
    check("no_false_bypass", data_sram_rdata, 32'h0BAD_F00D);

    // Out-of-range requests
    check_cnt("pre_oor");
    rd(OOR_ADDR);
    check("oor_rd_data", data_sram_rdata, 32'h0);
    check("oor_rd_err", {31'b0, addr_err}, 32'h1);
    idle();
    check("oor_err_pulse", {31'b0, addr_err}, 32'h0);
    rd(32'h10);
    wr(OOR_ADDR, 4'b1111, 32'h1234_5678);
    check("oor_wr_err", {31'b0, addr_err}, 32'h1);
    check("oor_wr_holds", data_sram_rdata, 32'hDEAD_BEEF);
    check_cnt("post_oor");
    rd(32'hFFFF_FFFC);
    check("oor_top_err", {31'b0, addr_err}, 32'h1);
    // Last in-range word
    wr(OOR_ADDR - 32'd4, 4'b1111, 32'h0F0F_0F0F);
    check("last_word_err", {31'b0, addr_err}, 32'h0);
    rd(OOR_ADDR - 32'd4);
    check("last_word", data_sram_rdata, 32'h0F0F_0F0F);

    // A pending write is discarded by reset
    wr(32'h40, 4'b1111, 32'h0000_0000);
    idle();
    wr(32'h40, 4'b1111, 32'hCAFE_F00D);
    reset = 1'b1;
    idle();
    check("rst2_rdata", data_sram_rdata, 32'h0);
    exp_rd = 32'd0;
    exp_wr = 32'd0;
    check_cnt("rst2");
    reset = 1'b0;
    rd(32'h40);
    check("discarded_wr", data_sram_rdata, 32'h0);

    // Counter traffic: 3 reads, 2 writes, 1 out-of-range read after reset
    reset = 1'b1;
    idle();
    reset = 1'b0;
    exp_rd = 32'd0;
    exp_wr = 32'd0;
    rd(32'h10);
    wr(32'h70, 4'b0001, 32'h0000_0011);
    rd(32'h20);
    wr(32'h74, 4'b1000, 32'h2200_0000);
    rd(OOR_ADDR);
    rd(32'h30);
    check("cnt_last_rd", data_sram_rdata, 32'h5566_7788);
`ifdef DATA_SRAM_STATS_EN
    check("stat_rd3", rd_cnt, 32'd3);
    check("stat_wr2", wr_cnt, 32'd2);
    @(negedge clk);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    exp_rd = 32'hFFFF_FFFF;
    rd(32'h10);
    check("stat_wrap", rd_cnt, 32'h0);
    check("stat_wrap_wr", wr_cnt, 32'd2);
`else
    check("nostat_rd", rd_cnt, 32'h0);
    check("nostat_wr", wr_cnt, 32'h0);
`endif
    check_cnt("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
